// File: rtl/pipeline_pkg.sv
// Shared pipeline types: register index type, zero register, MDU state
// encoding and the interlock debug snapshot.
package pipeline_pkg;

    localparam int REG_W = 5;

    typedef logic [REG_W-1:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = 5'd0;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mdu_state_e;

    // Internal state of the interlock, visible for observation and debug.
    typedef struct packed {
        mdu_state_e mduState;
        logic       ldValid;
        reg_idx_t   ldWs;
    } hazard_dbg_t;

    // True when the register can carry a dependency (r0 never does).
    function automatic logic regLive(input reg_idx_t idx);
        return idx != REG_ZERO;
    endfunction

endpackage

// File: rtl/hazard_stall_unit_if.sv
// Decode-slot description into the interlock and its stall/status results.
//
// Handshake: this is a level interface, not a valid/ready channel. The
// decode instruction is taken by the pipeline in a cycle where id_valid is
// high, stall is low and flush is low; while stall is high the producer
// must hold the same instruction on the bus.
interface hazard_stall_unit_if;
    import pipeline_pkg::*;

    logic        id_valid;
    reg_idx_t    rs;
    reg_idx_t    rt;
    logic        re1;
    logic        re2;
    reg_idx_t    id_ws;
    logic        id_we;
    logic        id_is_load;
    logic        id_is_mdu;
    logic        flush;
    logic        stall;
    logic        mdu_busy;
    reg_idx_t    mdu_ws;
    hazard_dbg_t dbg;

    // Decode side: presents the instruction, observes the interlock.
    modport master (
        output id_valid, rs, rt, re1, re2, id_ws, id_we, id_is_load,
               id_is_mdu, flush,
        input  stall, mdu_busy, mdu_ws, dbg
    );

    // Interlock side.
    modport slave (
        input  id_valid, rs, rt, re1, re2, id_ws, id_we, id_is_load,
               id_is_mdu, flush,
        output stall, mdu_busy, mdu_ws, dbg
    );

endinterface

// File: rtl/mdu_tracker.sv
// Tracks the single outstanding multi-cycle MDU operation: busy window,
// remaining cycles and destination register.
module mdu_tracker
    import pipeline_pkg::*;
#(
    parameter int MDU_LATENCY = 4,
    parameter int CNT_W       = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  reg_idx_t   startWs,
    output logic       busy,
    output reg_idx_t   ws,
    output mdu_state_e state
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_LATENCY - 1);

    mdu_state_e       stateQ;
    mdu_state_e       stateNext;
    logic [CNT_W-1:0] cntQ;
    logic [CNT_W-1:0] cntNext;
    reg_idx_t         wsQ;
    reg_idx_t         wsNext;

    // State, countdown and destination registers; reset abandons any op.
    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ <= IDLE;
            cntQ   <= '0;
            wsQ    <= REG_ZERO;
        end else begin
            stateQ <= stateNext;
            cntQ   <= cntNext;
            wsQ    <= wsNext;
        end
    end

    // Next state: start loads the countdown, BUSY counts down to zero.
    always_comb begin
        stateNext = stateQ;
        cntNext   = cntQ;
        wsNext    = wsQ;
        unique case (stateQ)
            IDLE: begin
                if (start) begin
                    stateNext = BUSY;
                    cntNext   = CNT_LOAD;
                    wsNext    = startWs;
                end
            end
            BUSY: begin
                if (cntQ == '0) begin
                    stateNext = IDLE;
                    wsNext    = REG_ZERO;
                end else begin
                    cntNext = cntQ - 1'b1;
                end
            end
            default: begin
                stateNext = IDLE;
                cntNext   = '0;
                wsNext    = REG_ZERO;
            end
        endcase
    end

    assign busy  = (stateQ == BUSY);
    assign ws    = wsQ;
    assign state = stateQ;

endmodule

// File: rtl/hazard_stall_unit.sv
// Issue-stage interlock: stalls decode on load-use and on MDU RAW, WAW and
// structural hazards. Everything else is left to the forwarding selectors.
module hazard_stall_unit
    import pipeline_pkg::*;
#(
    parameter int MDU_LATENCY = 4,
    parameter int CNT_W       = 3
) (
    input logic                 clk,
    input logic                 rst,
    hazard_stall_unit_if.slave  bus
);

    logic       accept;
    logic       ldValid;
    reg_idx_t   ldWs;
    logic       mduBusy;
    reg_idx_t   mduWs;
    mdu_state_e mduState;
    logic       loadUse;
    logic       mduRaw;
    logic       mduWaw;
    logic       mduStruct;
    logic       stallInt;

    assign accept = bus.id_valid & ~stallInt & ~bus.flush;

    // Load one stage ahead; any non-accept cycle drops it so a bubble never
    // re-triggers the interlock.
    always_ff @(posedge clk) begin
        if (rst) begin
            ldValid <= 1'b0;
            ldWs    <= REG_ZERO;
        end else begin
            ldValid <= accept & bus.id_is_load & bus.id_we & regLive(bus.id_ws);
            ldWs    <= bus.id_ws;
        end
    end

    mdu_tracker #(
        .MDU_LATENCY (MDU_LATENCY),
        .CNT_W       (CNT_W)
    ) u_mdu_tracker (
        .clk     (clk),
        .rst     (rst),
        .start   (accept & bus.id_is_mdu),
        .startWs (bus.id_we ? bus.id_ws : REG_ZERO),
        .busy    (mduBusy),
        .ws      (mduWs),
        .state   (mduState)
    );

    // Hazard terms; all are ORed without priority and squashed by flush.
    always_comb begin
        loadUse   = ldValid & ((bus.re1 & (bus.rs == ldWs)) |
                               (bus.re2 & (bus.rt == ldWs)));
        mduRaw    = mduBusy & regLive(mduWs) &
                    ((bus.re1 & (bus.rs == mduWs)) |
                     (bus.re2 & (bus.rt == mduWs)));
        mduWaw    = mduBusy & bus.id_we & (bus.id_ws == mduWs) & regLive(mduWs);
        mduStruct = mduBusy & bus.id_is_mdu;
        stallInt  = bus.id_valid & ~bus.flush &
                    (loadUse | mduRaw | mduWaw | mduStruct);
    end

    assign bus.stall         = stallInt;
    assign bus.mdu_busy      = mduBusy;
    assign bus.mdu_ws        = mduWs;
    assign bus.dbg.mduState  = mduState;
    assign bus.dbg.ldValid   = ldValid;
    assign bus.dbg.ldWs      = ldWs;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit with MDU_LATENCY = 4.
module tb_hazard_stall_unit;
    import pipeline_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    hazard_stall_unit_if bus ();

    hazard_stall_unit #(
        .MDU_LATENCY (4),
        .CNT_W       (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs are driven and outputs checked 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Driver tasks
    task automatic present(input logic v, input logic [4:0] rsI, input logic r1,
                           input logic [4:0] rtI, input logic r2,
                           input logic [4:0] ws, input logic we,
                           input logic ld, input logic mdu);
        bus.id_valid   = v;
        bus.rs         = rsI;
        bus.re1        = r1;
        bus.rt         = rtI;
        bus.re2        = r2;
        bus.id_ws      = ws;
        bus.id_we      = we;
        bus.id_is_load = ld;
        bus.id_is_mdu  = mdu;
        #1;
    endtask

    task automatic idle();
        present(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 12; i++) begin
            if (!bus.mdu_busy) break;
            tick();
        end
        chk(tag, {31'd0, bus.mdu_busy}, 32'd0);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        bus.flush = 1'b0;
        idle();
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk("rst_stall", {31'd0, bus.stall}, 32'd0);
        chk("rst_busy", {31'd0, bus.mdu_busy}, 32'd0);
        chk("rst_mdu_ws", {27'd0, bus.mdu_ws}, 32'd0);
        chk("rst_state", {31'd0, bus.dbg.mduState}, {31'd0, IDLE});
        chk("rst_ld_v", {31'd0, bus.dbg.ldValid}, 32'd0);

        // Load r5 then reader of r5: exactly one stall cycle
        present(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        chk("ld5_issue_stall", {31'd0, bus.stall}, 32'd0);
        tick();
        present(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
        chk("ld5_use_stall", {31'd0, bus.stall}, 32'd1);
        chk("ld5_ld_v", {31'd0, bus.dbg.ldValid}, 32'd1);
        tick();
        chk("ld5_use_release", {31'd0, bus.stall}, 32'd0);
        chk("ld5_ld_v_clear", {31'd0, bus.dbg.ldValid}, 32'd0);
        tick();

        // Load to r0 then reader of r0: no stall
        present(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
        tick();
        present(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
        chk("ld0_no_stall", {31'd0, bus.stall}, 32'd0);
        chk("ld0_ld_v", {31'd0, bus.dbg.ldValid}, 32'd0);
        tick();

        // Load r7; rt path only stalls when re2 is set
        present(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);
        tick();
        present(1'b1, 5'd0, 1'b0, 5'd7, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
        chk("ld7_re2_off", {31'd0, bus.stall}, 32'd0);
        present(1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
        chk("ld7_rt_use", {31'd0, bus.stall}, 32'd1);
        tick();
        chk("ld7_rt_release", {31'd0, bus.stall}, 32'd0);
        tick();
        idle();

        // MDU to r8 in cycle 0, reader of r8 from cycle 1
        present(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b1);
        chk("mdu8_issue", {31'd0, bus.stall}, 32'd0);
        tick();
        present(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            chk($sformatf("mdu8_raw_stall_c%0d", c), {31'd0, bus.stall}, 32'd1);
            chk($sformatf("mdu8_busy_c%0d", c), {31'd0, bus.mdu_busy}, 32'd1);
            chk($sformatf("mdu8_ws_c%0d", c), {27'd0, bus.mdu_ws}, 32'd8);
            tick();
        end
        chk("mdu8_raw_release", {31'd0, bus.stall}, 32'd0);
        chk("mdu8_busy_done", {31'd0, bus.mdu_busy}, 32'd0);
        chk("mdu8_ws_done", {27'd0, bus.mdu_ws}, 32'd0);
        tick();
        idle();

        // MDU r9, independent ALU in cycle 1, second MDU r10 from cycle 2
        present(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b1);
        tick();
        present(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
        chk("alu_indep", {31'd0, bus.stall}, 32'd0);
        tick();
        present(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0, 1'b1);
        for (int c = 2; c <= 4; c++) begin
            chk($sformatf("mdu_struct_c%0d", c), {31'd0, bus.stall}, 32'd1);
            tick();
        end
        chk("mdu_struct_accept", {31'd0, bus.stall}, 32'd0);
        chk("mdu_struct_idle", {31'd0, bus.mdu_busy}, 32'd0);
        tick();
        idle();
        for (int c = 6; c <= 9; c++) begin
            chk($sformatf("mdu10_busy_c%0d", c), {31'd0, bus.mdu_busy}, 32'd1);
            chk($sformatf("mdu10_ws_c%0d", c), {27'd0, bus.mdu_ws}, 32'd10);
            tick();
        end
        chk("mdu10_busy_c10", {31'd0, bus.mdu_busy}, 32'd0);

        // WAW: ALU to r8 while MDU r8 busy
        present(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b1);
        tick();
        present(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0);
        chk("waw_we0", {31'd0, bus.stall}, 32'd0);
        tick();
        present(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
        for (int c = 2; c <= 4; c++) begin
            chk($sformatf("waw_stall_c%0d", c), {31'd0, bus.stall}, 32'd1);
            tick();
        end
        chk("waw_release", {31'd0, bus.stall}, 32'd0);
        tick();
        idle();

        // MDU without write-enable tracks destination 0
        present(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b0, 1'b0, 1'b1);
        tick();
        present(1'b1, 5'd12, 1'b1, 5'd0, 1'b0, 5'd13, 1'b1, 1'b0, 1'b0);
        chk("mdu_nowe_busy", {31'd0, bus.mdu_busy}, 32'd1);
        chk("mdu_nowe_ws", {27'd0, bus.mdu_ws}, 32'd0);
        chk("mdu_nowe_no_stall", {31'd0, bus.stall}, 32'd0);
        tick();
        idle();
        wait_idle("mdu_nowe_wait_idle");

        // Flush squashes load-use
        present(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0);
        tick();
        bus.flush = 1'b1;
        present(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
        chk("flush_stall", {31'd0, bus.stall}, 32'd0);
        tick();
        bus.flush = 1'b0;
        #1;
        chk("flush_ld_v", {31'd0, bus.dbg.ldValid}, 32'd0);
        chk("flush_reader", {31'd0, bus.stall}, 32'd0);
        tick();
        idle();

        // Reset abandons an MDU op mid-count
        present(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b1);
        tick();
        idle();
        tick();
        chk("rst_mid_busy_before", {31'd0, bus.mdu_busy}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_busy", {31'd0, bus.mdu_busy}, 32'd0);
        chk("rst_mid_ws", {27'd0, bus.mdu_ws}, 32'd0);
        chk("rst_mid_state", {31'd0, bus.dbg.mduState}, {31'd0, IDLE});
        tick();

        // Load-use and MDU RAW together: stall until both clear
        present(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b1);
        tick();
        present(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0);
        chk("both_load_issue", {31'd0, bus.stall}, 32'd0);
        tick();
        present(1'b1, 5'd4, 1'b1, 5'd8, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
        chk("both_c2_ld_v", {31'd0, bus.dbg.ldValid}, 32'd1);
        for (int c = 2; c <= 4; c++) begin
            chk($sformatf("both_stall_c%0d", c), {31'd0, bus.stall}, 32'd1);
            tick();
        end
        chk("both_release", {31'd0, bus.stall}, 32'd0);
        tick();
        idle();

        // Final report
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
